// File: rtl/hazard_ctrl.sv
// hazard_ctrl: control end of the ID/EX pipeline-register interface.
// Generates PC / IF/ID / ID/EX enables for load-use stalls, branch flushes
// resolved in MEM, and stalls behind the multi-cycle mult/div unit. Also
// tracks mult/div occupancy and keeps a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MD_LAT = 32,  // mult/div EX occupancy, 1..63
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_muldiv,
    input  logic             id_hilo_rd,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             mem_br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] MD_LAT_C = 6'(MD_LAT);

    logic [5:0]       md_cnt_q, md_cnt_d;
    logic             md_young_q, md_young_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic unit_busy;
    logic load_use;
    logic md_hazard;
    logic stall;
    logic launch;

    // Hazard detection; r0 never creates a dependency, and a taken branch
    // kills the stalled instruction anyway so it suppresses the stall.
    always_comb begin
        unit_busy = (md_cnt_q != 6'd0);
        load_use  = ex_MemRead && (ex_rt != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rt)) ||
                     (id_use_rt && (id_rt == ex_rt)));
        md_hazard = unit_busy && (id_muldiv || id_hilo_rd);
        stall     = (load_use || md_hazard) && !mem_br_taken;
    end

    // Pipeline enables: flush beats stall beats normal advance; all quiet in reset.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;  // reserved, never asserted
        md_busy     = 1'b0;
        if (!rst) begin
            md_busy = unit_busy;
            idex_en = 1'b1;
            if (mem_br_taken) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall) begin
                idex_bubble = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    // Mult/div occupancy: a launch loads the full latency; a branch taken the
    // cycle after launch means the mult/div was younger and never really ran.
    always_comb begin
        launch     = id_muldiv && idex_en && !idex_bubble;
        md_cnt_d   = md_cnt_q;
        md_young_d = 1'b0;
        if (launch) begin
            md_cnt_d   = MD_LAT_C;
            md_young_d = 1'b1;
        end else if (mem_br_taken && md_young_q) begin
            md_cnt_d   = 6'd0;
        end else if (unit_busy) begin
            md_cnt_d   = md_cnt_q - 6'd1;
        end
    end

    // Stall counter saturates at all-ones; flush cycles are never stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q    <= 6'd0;
            md_young_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            md_young_q  <= md_young_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_LAT=4, CNT_W=4.
module tb_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
    logic             id_use_rs = 0, id_use_rt = 0, id_muldiv = 0, id_hilo_rd = 0;
    logic             ex_MemRead = 0, mem_br_taken = 0;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_flush, md_busy;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_muldiv(id_muldiv), .id_hilo_rd(id_hilo_rd),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_br_taken(mem_br_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .md_busy(md_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, xrt;
        logic       use_rs, use_rt, hilo, mr, br;
        logic       e_pc, e_ifid, e_flush, e_bub, e_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_muldiv = 0; id_hilo_rd = 0; ex_MemRead = 0; mem_br_taken = 0;
    endtask

    task automatic sat_inc();
        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    endtask

    task automatic chk_normal(input string name);
        chk({name, ".pc_en"}, pc_en, 1);
        chk({name, ".ifid_en"}, ifid_en, 1);
        chk({name, ".ifid_flush"}, ifid_flush, 0);
        chk({name, ".idex_en"}, idex_en, 1);
        chk({name, ".idex_bubble"}, idex_bubble, 0);
    endtask

    task automatic chk_stall(input string name);
        chk({name, ".pc_en"}, pc_en, 0);
        chk({name, ".ifid_en"}, ifid_en, 0);
        chk({name, ".ifid_flush"}, ifid_flush, 0);
        chk({name, ".idex_en"}, idex_en, 1);
        chk({name, ".idex_bubble"}, idex_bubble, 1);
    endtask

    task automatic chk_flush(input string name);
        chk({name, ".pc_en"}, pc_en, 1);
        chk({name, ".ifid_en"}, ifid_en, 1);
        chk({name, ".ifid_flush"}, ifid_flush, 1);
        chk({name, ".idex_en"}, idex_en, 1);
        chk({name, ".idex_bubble"}, idex_bubble, 1);
    endtask

    initial begin
        //                name       rs  rt  xrt urs urt hilo mr br  pc ifid fl bub stall
        vecs[0] = '{"idle",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[1] = '{"lu_rs",     5'd8, 5'd3, 5'd8, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1};
        vecs[2] = '{"r0_exempt", 5'd0, 5'd0, 5'd0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0};
        vecs[3] = '{"lu_rt",     5'd1, 5'd5, 5'd5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1};
        vecs[4] = '{"rt_unused", 5'd1, 5'd5, 5'd5, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0};
        vecs[5] = '{"no_load",   5'd8, 5'd8, 5'd8, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[6] = '{"reg_diff",  5'd7, 5'd9, 5'd8, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0};
        vecs[7] = '{"flush_lu",  5'd8, 5'd3, 5'd8, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        vecs[8] = '{"br_only",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        vecs[9] = '{"hilo_idle", 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0};

        // Reset state
        #3;
        chk("rst.pc_en", pc_en, 0);
        chk("rst.ifid_en", ifid_en, 0);
        chk("rst.idex_en", idex_en, 0);
        chk("rst.bubble", idex_bubble, 0);
        chk("rst.md_busy", md_busy, 0);
        chk("rst.stall_cnt", stall_cnt, 0);
        @(negedge clk); rst = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rt = vecs[i].xrt;
            id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
            id_hilo_rd = vecs[i].hilo; ex_MemRead = vecs[i].mr; mem_br_taken = vecs[i].br;
            id_muldiv = 1'b0;
            #2;
            chk({vecs[i].name, ".pc_en"}, pc_en, vecs[i].e_pc);
            chk({vecs[i].name, ".ifid_en"}, ifid_en, vecs[i].e_ifid);
            chk({vecs[i].name, ".ifid_flush"}, ifid_flush, vecs[i].e_flush);
            chk({vecs[i].name, ".idex_en"}, idex_en, 1);
            chk({vecs[i].name, ".idex_bubble"}, idex_bubble, vecs[i].e_bub);
            chk({vecs[i].name, ".exmem_flush"}, exmem_flush, 0);
            chk({vecs[i].name, ".md_busy"}, md_busy, 0);
            @(posedge clk); #1;
            if (vecs[i].e_stall) sat_inc();
            chk({vecs[i].name, ".stall_cnt"}, stall_cnt, exp_cnt);
        end

        // Mult then mflo: busy MD_LAT cycles, mflo stalls MD_LAT cycles
        @(negedge clk); clear_in(); id_muldiv = 1'b1;
        #2; chk_normal("md_launch"); chk("md_launch.busy", md_busy, 0);
        @(negedge clk); id_muldiv = 1'b0; id_hilo_rd = 1'b1;
        for (int c = 0; c < MD_LAT; c++) begin
            #2; chk_stall("mflo_wait"); chk("mflo_wait.busy", md_busy, 1);
            @(posedge clk); #1; sat_inc();
            chk("mflo_wait.stall_cnt", stall_cnt, exp_cnt);
            @(negedge clk);
        end
        #2; chk_normal("mflo_go"); chk("mflo_go.busy", md_busy, 0);
        @(posedge clk); #1; chk("mflo_go.stall_cnt", stall_cnt, exp_cnt);

        // Branch the cycle after launch kills the young mult
        @(negedge clk); clear_in(); id_muldiv = 1'b1;
        @(negedge clk); id_muldiv = 1'b0; mem_br_taken = 1'b1;
        #2; chk_flush("kill_young"); chk("kill_young.busy", md_busy, 1);
        @(negedge clk); mem_br_taken = 1'b0;
        #2; chk("kill_young.after_busy", md_busy, 0); chk_normal("kill_young.after");
        chk("kill_young.stall_cnt", stall_cnt, exp_cnt);

        // Branch two cycles after launch does not cancel the running unit
        @(negedge clk); id_muldiv = 1'b1;
        @(negedge clk); id_muldiv = 1'b0;
        @(negedge clk); mem_br_taken = 1'b1;
        #2; chk_flush("old_md_br");
        @(negedge clk); mem_br_taken = 1'b0;
        #2; chk("old_md_br.busy", md_busy, 1);
        for (int c = 0; c < 2 * MD_LAT && md_busy; c++) @(negedge clk);
        #1; chk("old_md_br.drain", md_busy, 0);

        // Saturation: hold a load-use for 20 cycles
        @(negedge clk); clear_in();
        ex_MemRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1; sat_inc();
            chk("sat.pc_en", pc_en, 0);
            chk("sat.stall_cnt", stall_cnt, exp_cnt);
        end
        chk("sat.final", stall_cnt, 15);

        // Reset during an active mult/div
        @(negedge clk); clear_in(); id_muldiv = 1'b1;
        @(negedge clk); id_muldiv = 1'b0;
        #1; chk("rst_md.busy_before", md_busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_md.busy", md_busy, 0);
        chk("rst_md.stall_cnt", stall_cnt, 0);
        chk("rst_md.pc_en", pc_en, 0);
        chk("rst_md.ifid_en", ifid_en, 0);
        chk("rst_md.idex_en", idex_en, 0);
        @(negedge clk); rst = 1'b0;
        #2; chk_normal("post_rst"); chk("post_rst.busy", md_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller: the control end of the ID/EX pipeline-register interface.
- Decides each cycle whether the PC, IF/ID and ID/EX registers advance, hold, or load a bubble.
- Handles load-use stalls, taken-branch flushes resolved in MEM, and stalls behind an in-flight multi-cycle multiply/divide.
- Keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MD_LAT, default 32: EX-stage mult/div occupancy in cycles; legal range 1..63.
- CNT_W, default 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in IF/ID.
- id_rt  in  5  rt field of the instruction in IF/ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_muldiv  in  1  ID instruction is mult/multu/div/divu.
- id_hilo_rd  in  1  ID instruction is mfhi/mflo.
- ex_MemRead  in  1  MemRead_out of the ID/EX register.
- ex_rt  in  5  rtOut of the ID/EX register.
- mem_br_taken  in  1  branch in EX/MEM is taken (Branch & zero).
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  drives ID/EX enReg.
- idex_bubble  out  1  ID/EX loads all-zero control signals.
- exmem_flush  out  1  zero EX/MEM control signals at the next edge.
- md_busy  out  1  mult/div unit occupied.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
Combinational hazard terms:
- load_use = ex_MemRead & (ex_rt != 0) & ((id_use_rs & id_rs == ex_rt) | (id_use_rt & id_rt == ex_rt)).
- md_hazard = md_busy & (id_muldiv | id_hilo_rd).
- stall = (load_use | md_hazard) & ~mem_br_taken.

Output rules, in priority order:
- mem_br_taken=1 (flush wins):
  - pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1, exmem_flush=0.
  - The instructions in IF/ID and ID/EX are younger than the branch and are killed.
- stall=1:
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_en=1, idex_bubble=1.
- Otherwise:
  - pc_en=1, ifid_en=1, ifid_flush=0, idex_en=1, idex_bubble=0.
- exmem_flush is reserved and held 0 in this revision.

Mult/div tracking:
- md_cnt: 6-bit down-counter.
- md_young: 1 bit, set when a mult/div was loaded into ID/EX at the last edge.
- md_busy = (md_cnt != 0).
- Launch: id_muldiv & idex_en & ~idex_bubble. At the next edge md_cnt <= MD_LAT and md_young <= 1.
- Else if mem_br_taken & md_young: md_cnt <= 0 and md_young <= 0. The killed mult/div never occupies the unit.
- Else if md_cnt != 0: md_cnt decrements, md_young <= 0.
- A launch can only occur when md_busy=0, because md_hazard blocks a second mult/div.

Stall counter:
- Increments by 1 on every edge where stall=1.
- Saturates at all-ones and never wraps.
- Branch-flush cycles are not counted.

## Timing
Reset (rst=1, asynchronous):
- md_cnt=0, md_young=0, stall_cnt=0.
- Combinational outputs forced to pc_en=0, ifid_en=0, idex_en=0, ifid_flush=0, idex_bubble=0, exmem_flush=0, md_busy=0.
- On deassertion, the first edge behaves per the Operation rules.
- Reset mid-mult/div: the counter clears immediately and md_busy drops asynchronously.

Latency:
- All enable/flush outputs are combinational from the current inputs and state, with zero-cycle latency.
- The registers they drive act on the same edge.
- Load-use costs exactly 1 stall cycle: after the bubble, ex_MemRead=0, so load_use clears.
- Mult/div: md_busy is high for exactly MD_LAT cycles, starting the cycle after launch.
- A dependent mfhi in ID stalls until the first cycle md_busy=0, then advances.
- Simultaneous load_use and mem_br_taken: flush only, no stall, counter unchanged.
- Simultaneous stall and md_cnt decrement: the counter still decrements, since the unit runs independently of stalls.

## Test plan
- Load-use:
  - Stimulus: ex_MemRead=1, ex_rt=8, id_rs=8, id_use_rs=1 for 1 cycle, then ex_MemRead=0.
  - Required: pc_en=0, ifid_en=0, idex_bubble=1 for exactly 1 cycle; stall_cnt 0->1.
- r0 exemption:
  - Stimulus: ex_MemRead=1, ex_rt=0, id_rs=0, id_use_rs=1.
  - Required: no stall, pc_en=1, stall_cnt unchanged.
- Mult/div then mflo:
  - Stimulus: MD_LAT=4; launch mult, then id_hilo_rd=1 on the next cycle.
  - Required: md_busy high 4 cycles, mflo stalled 4 cycles, stall_cnt=4, advance on the 5th cycle.
- Branch kills a young mult/div:
  - Stimulus: launch mult; on the next cycle mem_br_taken=1.
  - Required: ifid_flush=1, idex_bubble=1, md_cnt=0 after the edge; md_busy low from the following cycle.
- Flush beats stall:
  - Stimulus: load_use=1 and mem_br_taken=1 together.
  - Required: pc_en=1, ifid_flush=1, idex_bubble=1, stall_cnt unchanged.
- Saturation and reset:
  - Stimulus: CNT_W=4; hold stall for 20 cycles; then pulse rst mid-mult/div.
  - Required: stall_cnt sticks at 15; on rst, stall_cnt=0, md_busy=0 and all enables 0 immediately.
